// File: rtl/serial_operand_feeder.sv
// rtl/serial_operand_feeder.sv - parallel-to-serial operand front end for the serial adder, LSB first
module serial_operand_feeder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             a,
    output logic             b,
    output logic             bit_valid,
    output logic             first,
    output logic             last,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CW-1:0]    cnt;
    logic             at_last;
    logic             accept;
    logic             load;
    logic             shift_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The last bit of a frame doubles as the reload slot, so frames can abut.
    always_comb begin
        at_last    = (cnt == CNT_LAST);
        in_ready   = (state == IDLE) || (state == SHIFT && at_last);
        accept     = in_valid && in_ready;
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        a          = 1'b0;
        b          = 1'b0;
        bit_valid  = 1'b0;
        first      = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                a         = a_sr[0];
                b         = b_sr[0];
                bit_valid = 1'b1;
                first     = (cnt == '0);
                last      = at_last;
                if (!at_last) begin
                    shift_en = 1'b1;
                end else if (accept) begin
                    load = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        busy = bit_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr <= '0;
            b_sr <= '0;
            cnt  <= '0;
        end else if (load) begin
            a_sr <= a_in;
            b_sr <= b_in;
            cnt  <= '0;
        end else if (shift_en) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            cnt  <= cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// tb/tb_serial_operand_feeder.sv - self-checking bench for serial_operand_feeder (WIDTH=4 and WIDTH=1)
module tb_serial_operand_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       a, b, bit_valid, first, last, busy;

    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] a_in1;
    logic [0:0] b_in1;
    logic       a1, b1, bit_valid1, first1, last1, busy1;

    int total = 0;
    int bad   = 0;

    // Pending serial bits of the width-4 instance, front entry is on the wires now: {a, b, first, last}
    logic [3:0] mq[$];

    logic [6:0] obs;
    logic [6:0] obs1;
    assign obs  = {a, b, bit_valid, first, last, busy, in_ready};
    assign obs1 = {a1, b1, bit_valid1, first1, last1, busy1, in_ready1};

    always #5 clk = ~clk;

    serial_operand_feeder #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .a(a), .b(b), .bit_valid(bit_valid),
        .first(first), .last(last), .busy(busy)
    );

    serial_operand_feeder #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .a_in(a_in1), .b_in(b_in1), .a(a1), .b(b1), .bit_valid(bit_valid1),
        .first(first1), .last(last1), .busy(busy1)
    );

    function automatic bit model_edge();
        bit rdy;
        bit acc;
        rdy = (mq.size() <= 1);
        if (reset) begin
            mq.delete();
            return 1'b0;
        end
        if (mq.size() > 0) void'(mq.pop_front());
        acc = in_valid && rdy;
        if (acc)
            for (int i = 0; i < 4; i++)
                mq.push_back({a_in[i], b_in[i], (i == 0), (i == 3)});
        return acc;
    endfunction

    function automatic logic [6:0] model_out();
        logic [3:0] e;
        if (mq.size() == 0) return 7'b0000001;
        e = mq[0];
        return {e[3], e[2], 1'b1, e[1], e[0], 1'b1, (mq.size() <= 1)};
    endfunction

    task automatic step(output bit acc);
        @(posedge clk);
        acc = model_edge();
        #1;
    endtask

    task automatic test_reset();
        bit acc;
        reset = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0;
        in_valid1 = 1'b0; a_in1 = '0; b_in1 = '0;
        step(acc);
        step(acc);
        total++;
        if (obs !== 7'b0000001) begin
            bad++; $display("FAIL reset_state got=%b want=%b", obs, 7'b0000001);
        end
        total++;
        if (obs1 !== 7'b0000001) begin
            bad++; $display("FAIL reset_state_w1 got=%b want=%b", obs1, 7'b0000001);
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(acc);
            total++;
            if (obs !== 7'b0000001) begin
                bad++; $display("FAIL reset_idle c=%0d got=%b want=%b", c, obs, 7'b0000001);
            end
        end
    endtask

    task automatic test_single_frame();
        bit acc;
        logic [3:0] fa, fb;
        logic [6:0] exp;
        fa = 4'b0101; fb = 4'b1010;
        in_valid = 1'b1; a_in = fa; b_in = fb;
        step(acc);
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            exp = {fa[c], fb[c], 1'b1, (c == 0), (c == 3), 1'b1, (c == 3)};
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL single_frame c=%0d got=%b want=%b", c, obs, exp);
            end
            total++;
            if (obs !== model_out()) begin
                bad++; $display("FAIL single_model c=%0d got=%b want=%b", c, obs, model_out());
            end
            a_in = 4'($urandom); b_in = 4'($urandom);
            step(acc);
        end
        total++;
        if (obs !== 7'b0000001) begin
            bad++; $display("FAIL single_end got=%b want=%b", obs, 7'b0000001);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int idx;
        logic [3:0] pa[2], pb[2];
        logic [7:0] ea, eb, ef;
        pa[0] = 4'b0000; pb[0] = 4'b0001; pa[1] = 4'b1000; pb[1] = 4'b0010;
        ea = 8'b1000_0000; eb = 8'b0010_0001; ef = 8'b0001_0001;
        in_valid = 1'b1; a_in = pa[0]; b_in = pb[0];
        step(acc);
        idx = 1; a_in = pa[1]; b_in = pb[1];
        for (int c = 0; c < 8; c++) begin
            total++;
            if ({a, b, bit_valid, first} !== {ea[c], eb[c], 1'b1, ef[c]}) begin
                bad++;
                $display("FAIL b2b c=%0d got=%b want=%b", c, {a, b, bit_valid, first}, {ea[c], eb[c], 1'b1, ef[c]});
            end
            total++;
            if (obs !== model_out()) begin
                bad++; $display("FAIL b2b_model c=%0d got=%b want=%b", c, obs, model_out());
            end
            step(acc);
            if (acc) begin
                idx++;
                in_valid = 1'b0;
            end
        end
        total++;
        if (obs !== 7'b0000001) begin
            bad++; $display("FAIL b2b_end got=%b want=%b", obs, 7'b0000001);
        end
    endtask

    task automatic test_busy_ignore();
        bit acc;
        logic [7:0] ea;
        ea = 8'b1111_0101;
        in_valid = 1'b1; a_in = 4'b0101; b_in = 4'b1010;
        step(acc);
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) begin
                in_valid = 1'b1; a_in = 4'b1111; b_in = 4'($urandom);
            end
            total++;
            if (a !== ea[c] || bit_valid !== 1'b1) begin
                bad++; $display("FAIL busy_ignore c=%0d got a=%b bv=%b want a=%b bv=1", c, a, bit_valid, ea[c]);
            end
            total++;
            if (obs !== model_out()) begin
                bad++; $display("FAIL busy_model c=%0d got=%b want=%b", c, obs, model_out());
            end
            step(acc);
            if (acc) in_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid_frame();
        bit acc;
        in_valid = 1'b1; a_in = 4'b0101; b_in = 4'b1010;
        step(acc);
        in_valid = 1'b0;
        step(acc);
        total++;
        if (obs !== model_out()) begin
            bad++; $display("FAIL midrst_bit1 got=%b want=%b", obs, model_out());
        end
        reset = 1'b1; in_valid = 1'b1; a_in = 4'b1111; b_in = 4'b1111;
        step(acc);
        total++;
        if (obs !== 7'b0000001) begin
            bad++; $display("FAIL midrst_abort got=%b want=%b", obs, 7'b0000001);
        end
        step(acc);
        reset = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (obs !== 7'b0000001) begin
                bad++; $display("FAIL midrst_quiet c=%0d got=%b want=%b", c, obs, 7'b0000001);
            end
            step(acc);
        end
    endtask

    task automatic test_random();
        bit acc;
        for (int c = 0; c < 400; c++) begin
            in_valid = 1'($urandom);
            a_in = 4'($urandom); b_in = 4'($urandom);
            reset = ($urandom_range(0, 49) == 0);
            total++;
            if (obs !== model_out()) begin
                bad++; $display("FAIL random c=%0d got=%b want=%b", c, obs, model_out());
            end
            step(acc);
        end
        reset = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 5; c++) step(acc);
        total++;
        if (obs !== 7'b0000001) begin
            bad++; $display("FAIL random_drain got=%b want=%b", obs, 7'b0000001);
        end
    endtask

    task automatic test_width1();
        bit acc;
        in_valid1 = 1'b1; a_in1 = 1'b1; b_in1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (in_ready1 !== 1'b1) begin
                bad++; $display("FAIL w1_ready k=%0d got=%b want=1", k, in_ready1);
            end
            step(acc);
            total++;
            if (obs1 !== 7'b1111111) begin
                bad++; $display("FAIL w1_frame k=%0d got=%b want=%b", k, obs1, 7'b1111111);
            end
        end
        in_valid1 = 1'b0;
        step(acc);
        total++;
        if (obs1 !== 7'b0000001) begin
            bad++; $display("FAIL w1_end got=%b want=%b", obs1, 7'b0000001);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_frame();
        test_random();
        test_width1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
